// File: rtl/mem_io_hub_pkg.sv
// Shared definitions for the CPU memory/I-O hub: I/O addresses, read-source
// select encoding, stop-sequence state encoding and a byte-pick helper.
`timescale 1ns/1ps
package mem_io_hub_pkg;

  localparam logic [31:0] IO_UART = 32'h0003_0000;
  localparam logic [31:0] IO_CLK  = 32'h0003_0004;

  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_IO   = 2'd1,
    SRC_ZERO = 2'd2
  } rd_src_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } hub_state_t;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_io_hub_byte_fifo.sv
// Byte-wide FIFO with occupancy count; pushes when full and pops when empty
// are ignored, and the head byte reads as zero while empty.
`timescale 1ns/1ps
module byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        pop,
  output logic [7:0]  pop_data,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly log2(DEPTH) bits, so wrap is implicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_hub.sv
// CPU external-bus hub: RAM/I-O decode, 1-cycle read return, UART TX queue,
// UART RX pop, cycle counter snapshot and the program-stop drain sequence.
`timescale 1ns/1ps
module mem_io_hub
  import mem_io_hub_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2,
  parameter int RAM_AW      = 17,
  parameter int CNT_W       = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cpu_rdy,
  input  logic [31:0]       cpu_mem_a,
  input  logic [7:0]        cpu_mem_dout,
  input  logic              cpu_mem_wr,
  output logic [7:0]        cpu_mem_din,
  output logic              io_buffer_full,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_pop,
  output logic              prog_done,
  output logic              tx_overflow
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_TH = CW'(TX_DEPTH - FULL_MARGIN);
  localparam logic [17:0] OFF_UART = IO_UART[17:0];
  localparam logic [17:0] OFF_CLK  = IO_CLK[17:0];

  hub_state_t     state;
  rd_src_t        rd_src;
  logic [7:0]     io_byte;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] snapshot;
  logic [31:0]    snap32;
  logic           pend;

  logic           is_io;
  logic [17:0]    io_off;
  logic           uart_wr;
  logic           stop_wr;
  logic           fifo_push;
  logic [7:0]     fifo_push_data;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           unused_addr;

  assign is_io       = (cpu_mem_a[17:16] == 2'b11);
  assign io_off      = cpu_mem_a[17:0];
  assign unused_addr = ^cpu_mem_a[31:18];
  assign snap32      = 32'(snapshot);

  assign uart_wr = cpu_mem_wr && is_io && (io_off == OFF_UART) && (state == ST_RUN)
                   && (cpu_mem_dout != 8'h00);
  assign stop_wr = cpu_mem_wr && is_io && (io_off == OFF_CLK) && (state == ST_RUN);

  // The stop marker is a 0x00 byte; if the queue is full it waits in pend.
  assign fifo_push      = !fifo_full && (uart_wr || stop_wr || pend);
  assign fifo_push_data = uart_wr ? cpu_mem_dout : 8'h00;

  assign ram_a       = cpu_mem_a[RAM_AW-1:0];
  assign ram_dout    = cpu_mem_dout;
  assign ram_wr      = rst_in && cpu_mem_wr && !is_io && (state != ST_DONE);
  assign uart_rx_pop = rst_in && !cpu_mem_wr && is_io && (io_off == OFF_UART) && uart_rx_valid;
  assign cpu_mem_din = (rd_src == SRC_RAM) ? ram_din : io_byte;
  assign prog_done   = (state == ST_DONE);

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (uart_tx_valid && uart_tx_ready),
    .pop_data  (uart_tx_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign uart_tx_valid = !fifo_empty;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_src         <= SRC_ZERO;
      io_byte        <= 8'h00;
      counter        <= '0;
      snapshot       <= '0;
      pend           <= 1'b0;
      io_buffer_full <= 1'b0;
      tx_overflow    <= 1'b0;
    end else begin
      if (cpu_rdy && state == ST_RUN) counter <= counter + 1'b1;
      if (uart_wr && fifo_full) tx_overflow <= 1'b1;
      if (stop_wr && fifo_full) pend <= 1'b1;
      else if (pend && !fifo_full) pend <= 1'b0;
      io_buffer_full <= (fifo_count >= FULL_TH);

      if (cpu_mem_wr) begin
        rd_src  <= SRC_ZERO;
        io_byte <= 8'h00;
      end else if (!is_io) begin
        rd_src  <= SRC_RAM;
        io_byte <= 8'h00;
      end else begin
        rd_src <= SRC_IO;
        case (io_off)
          OFF_UART: io_byte <= uart_rx_valid ? uart_rx_data : 8'h00;
          OFF_CLK: begin
            snapshot <= counter;
            io_byte  <= counter[7:0];
          end
          OFF_CLK + 18'd1,
          OFF_CLK + 18'd2,
          OFF_CLK + 18'd3: io_byte <= byte_of(snap32, io_off[1:0]);
          default: io_byte <= 8'h00;
        endcase
      end
    end
  end

  // state    | meaning
  // ST_RUN   | normal operation, counter runs, writes accepted
  // ST_DRAIN | stop written, waiting for TX queue and stop marker to leave
  // ST_DONE  | program finished, terminal until reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (stop_wr) state <= ST_DRAIN;
        ST_DRAIN: if (fifo_empty && !pend) state <= ST_DONE;
        ST_DONE:  state <= ST_DONE;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_hub.sv
// Directed self-checking bench for mem_io_hub with a behavioural RAM and a
// log of every byte the UART accepts.
`timescale 1ns/1ps
module tb_mem_io_hub;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        cpu_rdy = 1'b0;
  logic [31:0] cpu_mem_a = '0;
  logic [7:0]  cpu_mem_dout = '0;
  logic        cpu_mem_wr = 1'b0;
  logic [7:0]  cpu_mem_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_pop;
  logic        prog_done;
  logic        tx_overflow;

  int total = 0;
  int bad = 0;

  logic [7:0]  ram_mem [0:131071];
  logic        pre_en = 1'b0;
  logic [16:0] pre_a = '0;
  logic [7:0]  pre_d = '0;
  logic [7:0]  tx_log [$];

  mem_io_hub dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_rdy(cpu_rdy),
    .cpu_mem_a(cpu_mem_a), .cpu_mem_dout(cpu_mem_dout), .cpu_mem_wr(cpu_mem_wr),
    .cpu_mem_din(cpu_mem_din), .io_buffer_full(io_buffer_full),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_pop(uart_rx_pop),
    .prog_done(prog_done), .tx_overflow(tx_overflow)
  );

  initial forever #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (pre_en) ram_mem[pre_a] <= pre_d;
    else if (ram_wr) ram_mem[ram_a] <= ram_dout;
    ram_din <= ram_mem[ram_a];
  end

  always @(posedge clk_in) begin
    if (rst_in && uart_tx_valid && uart_tx_ready) tx_log.push_back(uart_tx_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    cpu_mem_a = a; cpu_mem_dout = d; cpu_mem_wr = 1'b1;
    step();
    cpu_mem_wr = 1'b0; cpu_mem_a = '0; cpu_mem_dout = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
    cpu_mem_a = a; cpu_mem_wr = 1'b0;
    step();
    d = cpu_mem_din;
    cpu_mem_a = '0;
  endtask

  task automatic do_reset();
    cpu_mem_a = '0; cpu_mem_dout = '0; cpu_mem_wr = 1'b0;
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b0;
    rst_in = 1'b0;
    step(); step();
    tx_log.delete();
    rst_in = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (uart_tx_valid && n < 60) begin step(); n++; end
    total++;
    if (uart_tx_valid) begin bad++; $display("FAIL %s_timeout: tx_valid still %b after %0d cycles", name, uart_tx_valid, n); end
  endtask

  task automatic test_reset();
    #1 rst_in = 1'b0;
    step(); step();
    total++;
    if ({cpu_mem_din, uart_tx_data, io_buffer_full, uart_tx_valid, uart_rx_pop, prog_done, tx_overflow, ram_wr} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs: din=%h txd=%h full=%b txv=%b pop=%b done=%b ovf=%b rwr=%b, expected all 0",
               cpu_mem_din, uart_tx_data, io_buffer_full, uart_tx_valid, uart_rx_pop, prog_done, tx_overflow, ram_wr);
    end
    rst_in = 1'b1;
  endtask

  task automatic test_ram();
    logic [7:0] d;
    pre_en = 1'b1; pre_a = 17'h00100; pre_d = 8'hA5;
    step();
    pre_en = 1'b0;
    bus_read(32'h0000_0100, d);
    total++;
    if (d !== 8'hA5) begin bad++; $display("FAIL ram_read: got %h expected a5", d); end
    cpu_mem_a = 32'h0000_0101; cpu_mem_dout = 8'h3C; cpu_mem_wr = 1'b1;
    #1;
    total++;
    if (ram_wr !== 1'b1 || ram_a !== 17'h00101 || ram_dout !== 8'h3C) begin
      bad++; $display("FAIL ram_write_strobe: wr=%b a=%h d=%h expected 1/00101/3c", ram_wr, ram_a, ram_dout);
    end
    step();
    cpu_mem_wr = 1'b0; cpu_mem_a = '0; cpu_mem_dout = '0;
    bus_read(32'h0000_0101, d);
    total++;
    if (d !== 8'h3C) begin bad++; $display("FAIL ram_readback: got %h expected 3c", d); end
    bus_read(32'h0003_0010, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL io_other_read: got %h expected 00", d); end
  endtask

  task automatic test_tx();
    do_reset();
    uart_tx_ready = 1'b1;
    bus_write(32'h0003_0000, 8'h41);
    total++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
      bad++; $display("FAIL tx_first: valid=%b data=%h expected 1/41", uart_tx_valid, uart_tx_data);
    end
    bus_write(32'h0003_0000, 8'h00);
    total++;
    if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL tx_zero_ignored: valid=%b expected 0", uart_tx_valid); end
    bus_write(32'h0003_0000, 8'h42);
    step();
    total++;
    if (tx_log.size() != 2 || tx_log[0] !== 8'h41 || tx_log[1] !== 8'h42) begin
      bad++; $display("FAIL tx_sequence: got %0d bytes %p expected 41 42", tx_log.size(), tx_log);
    end

    uart_tx_ready = 1'b0;
    tx_log.delete();
    for (int i = 1; i <= 14; i++) bus_write(32'h0003_0000, 8'(i));
    total++;
    if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL full_latency: got %b expected 0 in the count=14 cycle", io_buffer_full); end
    step();
    total++;
    if (io_buffer_full !== 1'b1) begin bad++; $display("FAIL full_raised: got %b expected 1", io_buffer_full); end
    bus_write(32'h0003_0000, 8'd15);
    bus_write(32'h0003_0000, 8'd16);
    total++;
    if (tx_overflow !== 1'b0) begin bad++; $display("FAIL overflow_early: got %b expected 0", tx_overflow); end
    bus_write(32'h0003_0000, 8'd17);
    total++;
    if (tx_overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b expected 1", tx_overflow); end
    uart_tx_ready = 1'b1;
    wait_drain("tx_fill");
    step();
    total++;
    if (tx_log.size() != 16 || tx_log[0] !== 8'd1 || tx_log[15] !== 8'd16) begin
      bad++; $display("FAIL tx_fill_contents: got %0d bytes %p expected 1..16", tx_log.size(), tx_log);
    end
    total++;
    if (io_buffer_full !== 1'b0 || tx_overflow !== 1'b1) begin
      bad++; $display("FAIL after_drain_flags: full=%b ovf=%b expected 0/1", io_buffer_full, tx_overflow);
    end
  endtask

  task automatic test_counter();
    logic [7:0] d;
    cpu_rdy = 1'b1;
    do_reset();
    repeat (100) step();
    bus_read(32'h0003_0004, d);
    total++;
    if (d !== 8'h64) begin bad++; $display("FAIL cnt_byte0: got %h expected 64", d); end
    bus_read(32'h0003_0005, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL cnt_byte1: got %h expected 00", d); end
    bus_read(32'h0003_0006, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL cnt_byte2: got %h expected 00", d); end
    bus_read(32'h0003_0007, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL cnt_byte3: got %h expected 00", d); end
    repeat (200) step();
    bus_read(32'h0003_0004, d);
    total++;
    if (d !== 8'h30) begin bad++; $display("FAIL cnt2_byte0: got %h expected 30", d); end
    bus_read(32'h0003_0005, d);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL cnt2_byte1: got %h expected 01", d); end
    bus_read(32'h0003_0006, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL cnt2_byte2: got %h expected 00", d); end
    cpu_rdy = 1'b0;
    repeat (50) step();
    bus_read(32'h0003_0004, d);
    total++;
    if (d !== 8'h33) begin bad++; $display("FAIL cnt_gated: got %h expected 33", d); end
  endtask

  task automatic test_rx();
    uart_rx_valid = 1'b1; uart_rx_data = 8'h7E;
    cpu_mem_a = 32'h0003_0000; cpu_mem_wr = 1'b0;
    #1;
    total++;
    if (uart_rx_pop !== 1'b1) begin bad++; $display("FAIL rx_pop: got %b expected 1", uart_rx_pop); end
    step();
    total++;
    if (cpu_mem_din !== 8'h7E) begin bad++; $display("FAIL rx_data: got %h expected 7e", cpu_mem_din); end
    cpu_mem_a = '0;
    #1;
    total++;
    if (uart_rx_pop !== 1'b0) begin bad++; $display("FAIL rx_pop_single: got %b expected 0", uart_rx_pop); end
    uart_rx_valid = 1'b0;
    cpu_mem_a = 32'h0003_0000;
    #1;
    total++;
    if (uart_rx_pop !== 1'b0) begin bad++; $display("FAIL rx_nopop: got %b expected 0", uart_rx_pop); end
    step();
    total++;
    if (cpu_mem_din !== 8'h00) begin bad++; $display("FAIL rx_empty_data: got %h expected 00", cpu_mem_din); end
    cpu_mem_a = '0;
  endtask

  task automatic test_stop();
    int n = 0;
    do_reset();
    bus_write(32'h0003_0000, 8'h11);
    bus_write(32'h0003_0000, 8'h22);
    bus_write(32'h0003_0000, 8'h33);
    bus_write(32'h0003_0004, 8'h55);
    step();
    total++;
    if (prog_done !== 1'b0) begin bad++; $display("FAIL stop_not_done: got %b expected 0", prog_done); end
    uart_tx_ready = 1'b1;
    while (!prog_done && n < 30) begin step(); n++; end
    total++;
    if (prog_done !== 1'b1) begin bad++; $display("FAIL stop_done: got %b expected 1", prog_done); end
    total++;
    if (tx_log.size() != 4 || tx_log[0] !== 8'h11 || tx_log[1] !== 8'h22 || tx_log[2] !== 8'h33 || tx_log[3] !== 8'h00) begin
      bad++; $display("FAIL stop_sequence: got %0d bytes %p expected 11 22 33 00", tx_log.size(), tx_log);
    end
    cpu_mem_a = 32'h0000_0200; cpu_mem_dout = 8'h99; cpu_mem_wr = 1'b1;
    #1;
    total++;
    if (ram_wr !== 1'b0) begin bad++; $display("FAIL done_ram_wr: got %b expected 0", ram_wr); end
    step();
    cpu_mem_wr = 1'b0; cpu_mem_a = '0;
    bus_write(32'h0003_0000, 8'h77);
    total++;
    if (uart_tx_valid !== 1'b0 || prog_done !== 1'b1) begin
      bad++; $display("FAIL done_write_ignored: txv=%b done=%b expected 0/1", uart_tx_valid, prog_done);
    end
  endtask

  task automatic test_stop_full();
    int n = 0;
    do_reset();
    for (int i = 0; i < 16; i++) bus_write(32'h0003_0000, 8'(8'h20 + i));
    bus_write(32'h0003_0004, 8'h00);
    total++;
    if (tx_overflow !== 1'b0 || prog_done !== 1'b0) begin
      bad++; $display("FAIL stopfull_flags: ovf=%b done=%b expected 0/0", tx_overflow, prog_done);
    end
    uart_tx_ready = 1'b1;
    while (!prog_done && n < 60) begin step(); n++; end
    total++;
    if (prog_done !== 1'b1 || tx_log.size() != 17 || tx_log[15] !== 8'h2F || tx_log[16] !== 8'h00) begin
      bad++; $display("FAIL stopfull_pending: done=%b got %0d bytes %p expected 20..2f then 00", prog_done, tx_log.size(), tx_log);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    do_reset();
    cpu_rdy = 1'b1;
    bus_write(32'h0003_0000, 8'hAA);
    bus_write(32'h0003_0000, 8'hBB);
    bus_write(32'h0003_0004, 8'h01);
    bus_read(32'h0000_0100, d);
    total++;
    if (d !== 8'hA5 || uart_tx_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset_state: din=%h txv=%b expected a5/1", d, uart_tx_valid);
    end
    #2 rst_in = 1'b0;
    #1;
    total++;
    if ({cpu_mem_din, uart_tx_data, io_buffer_full, uart_tx_valid, uart_rx_pop, prog_done, tx_overflow, ram_wr} !== 22'd0) begin
      bad++;
      $display("FAIL async_reset_outputs: din=%h txd=%h full=%b txv=%b pop=%b done=%b ovf=%b rwr=%b, expected all 0",
               cpu_mem_din, uart_tx_data, io_buffer_full, uart_tx_valid, uart_rx_pop, prog_done, tx_overflow, ram_wr);
    end
    step();
    rst_in = 1'b1;
    repeat (3) step();
    bus_read(32'h0003_0004, d);
    total++;
    if (d !== 8'h03) begin bad++; $display("FAIL counter_restart: got %h expected 03", d); end
    cpu_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_rx();
    test_tx();
    test_counter();
    test_stop();
    test_stop_full();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
